wishbone_arbiter_2m: RTL and testbench
======================================

# wishbone_arbiter_2m

Two-master Wishbone arbiter that shares the single master port of `wishbone_interconnect` between the host `wishbone_master` (m0) and a second bus master such as a framebuffer DMA feeding the `tft` core (m1). It grants whole bus cycles (`cyc` held) using round-robin priority and muxes the selected master onto the interconnect. A bus watchdog aborts any cycle that a slave never acknowledges.

## Interface
- `TIMEOUT_CYCLES`, default 256: number of cycles a strobe may wait for `ack` before the cycle is aborted; legal range 2..65535.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 cycle, strobe and write-enable.
- `m0_sel_i` in 4: byte selects.
- `m0_adr_i` in 32: address.
- `m0_dat_i` in 32: write data.
- `m0_dat_o` out 32: read data from the slave.
- `m0_ack_o`, `m0_err_o`, `m0_int_o` out 1 each: acknowledge, abort error, and slave interrupt.
- `m1_*`: identical set of ports for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: to interconnect `m_*_i`.
- `s_sel_o` out 4, `s_adr_o` out 32, `s_dat_o` out 32: to interconnect.
- `s_dat_i` in 32, `s_ack_i` in 1, `s_int_i` in 1: from interconnect.
- `timeout_o` out 1: one-cycle pulse when an abort occurs.
- `grant_o` out 2: one-hot grant (bit n means mn owns the bus); `2'b00` when idle or aborting.

## Operation
- States: IDLE, GRANT0, GRANT1, ABORT. Register `last` records the most recently granted master. Reset sets `last` to 1, so m0 wins the first tie.
- IDLE → GRANTn when `mn_cyc_i` is high. If both are high, grant the master not equal to `last`. `last` is updated on entry to a GRANT state.
- GRANTn, when `mn_cyc_i` falls:
  - if the other master's `cyc` is high, go directly to that GRANT state;
  - otherwise go to IDLE.
- GRANTn with watchdog expiry → ABORT.
- ABORT → IDLE once the aborted master's `cyc` is low. A master still holding `cyc` keeps the arbiter in ABORT.
- Muxing is combinational from the state register:
  - In GRANTn, `s_cyc/stb/we/sel/adr/dat_o` follow mn's inputs.
  - `mn_ack_o` = `s_ack_i`, and `mn_dat_o` = `s_dat_i`.
  - The non-granted master sees `ack` = 0 and `dat_o` = 0.
- In IDLE and ABORT, all `s_*` outputs are 0 and both `ack` outputs are 0.
- `s_int_i` is broadcast to both `mn_int_o` in every state.
- Watchdog counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Cleared in IDLE, on any state change, and on any cycle with `s_ack_i` high.
  - Increments each cycle the arbiter is in GRANTn with `s_stb_o` high and `s_ack_i` low.
  - When the counter equals TIMEOUT_CYCLES−1 and a non-acked strobe is present, the next state is ABORT.
  - `mn_err_o` for the aborted master and `timeout_o` are registered pulses, high for exactly the first cycle of ABORT.
- An `s_ack_i` arriving in IDLE or ABORT is ignored and is never forwarded.

## Timing
- Grant latency: `cyc` seen in IDLE at edge k puts the bus on the interconnect from cycle k+1. Handover between masters has zero idle cycles.
- Data and `ack` paths are combinational, adding no cycles between slave and master.
- Reset values:
  - state IDLE;
  - all `s_*` outputs 0;
  - all `m*_ack/err` 0;
  - `m*_dat_o` 0;
  - `timeout_o` 0;
  - `grant_o` 0;
  - counter 0.
- Asserting `rst` mid-cycle drops `s_cyc_o` immediately (asynchronous). The arbiter restarts in IDLE and re-grants m0 first.
- An abort happens exactly TIMEOUT_CYCLES strobe-cycles without `ack`. An `ack` arriving in that same final cycle wins: no abort occurs and the counter clears.

## Structure
- The shared package `wb_arb_pkg` holds:
  - the state encodings (IDLE=0, GRANT0=1, GRANT1=2, ABORT=3);
  - the `TIMEOUT_CYCLES` default;
  - the counter-width function.
- One sub-module is natural: `wb_bus_watchdog`, which contains the counter and the expiry compare. It takes clk, rst, clear, count_en and produces `expire`.
- The state machine and the muxes stay in the top module.

## Test plan
- Single m0 read of address 0x00000000, with `s_ack_i` arriving 3 cycles after the grant:
  - `grant_o` = 01 one cycle after `m0_cyc_i`;
  - `m0_dat_o` = `s_dat_i` = 0x12345678 in the `ack` cycle;
  - m1 sees no `ack`.
- Both `cyc` rising on the same edge after reset:
  - m0 is granted first;
  - on m0 `cyc` low, `grant_o` = 10 on the next edge with no IDLE cycle;
  - a third simultaneous request goes to m0.
- m1 writes 0x01000004 ← 0xAABBCCDD while m0 requests mid-transfer:
  - `s_adr_o` and `s_dat_o` remain m1's values until m1 drops `cyc`.
- With TIMEOUT_CYCLES=8, the slave never acks an m0 strobe:
  - `s_cyc_o` falls after 8 strobe cycles;
  - `m0_err_o` and `timeout_o` pulse for 1 cycle;
  - state stays ABORT until m0 drops `cyc`, then m1 can be granted.
- With TIMEOUT_CYCLES=8, `ack` arrives on the 8th cycle: no err, and the transfer completes normally.
- `rst` pulsed asynchronously mid-grant:
  - `s_cyc_o` goes to 0 before the next clock edge;
  - after release, m0 wins a tie.
- `s_int_i` = 1 in IDLE, GRANT1 and ABORT: both `m*_int_o` = 1 in each state.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// watchdog default and the counter-width helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

  // Counter must hold values up to TIMEOUT_CYCLES inclusive.
  function automatic int unsigned wdt_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus watchdog: counts unacknowledged strobe cycles and flags expiry on the
// last permitted cycle so the arbiter can abort on the following edge.
module wb_bus_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expire
);

  localparam int unsigned CNT_W = wdt_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Expiry is gated by count_en, so an ack in the final cycle suppresses it.
  assign o_expire = i_count_en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/wishbone_arbiter_2m.sv
// Round-robin arbiter sharing one Wishbone master port between two masters,
// granting whole cyc-held cycles and aborting cycles a slave never acks.
module wishbone_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  // master 0
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_int_o,
  // master 1
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_int_o,
  // shared slave side
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_int_i,
  output logic        timeout_o,
  output logic [1:0]  grant_o
);

  arb_state_e r_state;
  arb_state_e w_next;
  logic       r_last;
  logic       r_timeout;
  logic       r_err0;
  logic       r_err1;
  logic       w_granted;
  logic       w_abort_entry;
  logic       w_wdt_clear;
  logic       w_wdt_count;
  logic       w_wdt_expire;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = r_last ? ST_GRANT0 : ST_GRANT1;
        end else if (m0_cyc_i) begin
          w_next = ST_GRANT0;
        end else if (m1_cyc_i) begin
          w_next = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (!m0_cyc_i) begin
          w_next = m1_cyc_i ? ST_GRANT1 : ST_IDLE;
        end else if (w_wdt_expire) begin
          w_next = ST_ABORT;
        end
      end
      ST_GRANT1: begin
        if (!m1_cyc_i) begin
          w_next = m0_cyc_i ? ST_GRANT0 : ST_IDLE;
        end else if (w_wdt_expire) begin
          w_next = ST_ABORT;
        end
      end
      ST_ABORT: begin
        // r_last still names the master whose cycle was aborted.
        if (!(r_last ? m1_cyc_i : m0_cyc_i)) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output muxing, driven from the state register only
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    case (r_state)
      ST_GRANT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
      ST_GRANT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

  assign grant_o  = {r_state == ST_GRANT1, r_state == ST_GRANT0};
  assign m0_int_o = s_int_i;
  assign m1_int_o = s_int_i;

  // Round-robin history and one-cycle abort pulses
  assign w_abort_entry = (w_next == ST_ABORT) && (r_state != ST_ABORT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last    <= 1'b1;
      r_timeout <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
    end else begin
      if (w_next == ST_GRANT0 && r_state != ST_GRANT0) begin
        r_last <= 1'b0;
      end else if (w_next == ST_GRANT1 && r_state != ST_GRANT1) begin
        r_last <= 1'b1;
      end
      r_timeout <= w_abort_entry;
      r_err0    <= w_abort_entry && (r_state == ST_GRANT0);
      r_err1    <= w_abort_entry && (r_state == ST_GRANT1);
    end
  end

  assign timeout_o = r_timeout;
  assign m0_err_o  = r_err0;
  assign m1_err_o  = r_err1;

  // Watchdog control
  assign w_granted   = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
  assign w_wdt_count = w_granted && s_stb_o && !s_ack_i;
  assign w_wdt_clear = (r_state == ST_IDLE) || (w_next != r_state) || s_ack_i;

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_wdt_clear),
    .i_count_en(w_wdt_count),
    .o_expire  (w_wdt_expire)
  );

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Directed bench for wishbone_arbiter_2m: expected values are queued when
// stimulus is applied and popped as DUT outputs are sampled on the falling edge.
module tb_wishbone_arbiter_2m;

  logic        clk;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_int_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_int_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i, s_int_i, timeout_o;
  logic [1:0]  grant_o;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_strobe;
  logic [31:0] adr_first;

  wishbone_arbiter_2m #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_int_o(m0_int_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_int_o(m1_int_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_int_i(s_int_i), .timeout_o(timeout_o), .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, expected finish before 100us");
    $fatal(1, "simulation time limit");
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow: observed %h, expected a queued value", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
    m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
    m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_int_i = 1'b0;

    // Reset values
    expect_val("rst_s_cyc", 0); expect_val("rst_grant", 0); expect_val("rst_m0_dat", 0);
    expect_val("rst_ack", 0);   expect_val("rst_err", 0);   expect_val("rst_timeout", 0);
    @(negedge clk);
    check(s_cyc_o); check(grant_o); check(m0_dat_o);
    check({m0_ack_o, m1_ack_o}); check({m0_err_o, m1_err_o}); check(timeout_o);

    // Single m0 read, ack three cycles after grant
    tick(); rst = 1'b0;
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 4'hf; m0_adr_i = 32'h0;
    expect_val("t1_latency_s_cyc", 0);
    @(negedge clk); check(s_cyc_o);
    tick();
    expect_val("t1_grant", 2'b01); expect_val("t1_s_cyc", 1); expect_val("t1_s_adr", 32'h0);
    @(negedge clk); check(grant_o); check(s_cyc_o); check(s_adr_o);
    tick(); tick();
    tick(); s_ack_i = 1; s_dat_i = 32'h12345678;
    expect_val("t1_m0_ack", 1); expect_val("t1_m0_dat", 32'h12345678);
    expect_val("t1_m1_ack", 0); expect_val("t1_m1_dat", 0);
    @(negedge clk); check(m0_ack_o); check(m0_dat_o); check(m1_ack_o); check(m1_dat_o);
    tick(); s_ack_i = 0; s_dat_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    expect_val("t1_idle_grant", 0);
    @(negedge clk); check(grant_o);

    // Simultaneous requests after reset: m0, then m1 with no gap, then m0 again
    tick(); rst = 1;
    tick(); rst = 0;
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0100_0000;
    tick();
    expect_val("t2_first_grant", 2'b01);
    @(negedge clk); check(grant_o);
    tick(); s_ack_i = 1; s_dat_i = 32'hCAFE0000;
    expect_val("t2_m0_ack", 1); expect_val("t2_m1_ack", 0); expect_val("t2_m1_dat", 0);
    @(negedge clk); check(m0_ack_o); check(m1_ack_o); check(m1_dat_o);
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    expect_val("t2_handover_grant", 2'b10);
    @(negedge clk); check(grant_o);
    tick(); s_ack_i = 1;
    expect_val("t2_m1_ack_g1", 1); expect_val("t2_m0_ack_g1", 0);
    @(negedge clk); check(m1_ack_o); check(m0_ack_o);
    tick(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick();
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    expect_val("t2_third_grant", 2'b01);
    @(negedge clk); check(grant_o);
    tick(); m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick();

    // m1 write held against a mid-transfer m0 request
    tick(); m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hf;
    m1_adr_i = 32'h0100_0004; m1_dat_i = 32'hAABBCCDD;
    tick();
    expect_val("t3_grant", 2'b10);
    @(negedge clk); check(grant_o);
    tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'hDEAD0000; m0_dat_i = 32'h11111111;
    expect_val("t3_adr", 32'h0100_0004); expect_val("t3_dat", 32'hAABBCCDD); expect_val("t3_we", 1);
    @(negedge clk); check(s_adr_o); check(s_dat_o); check(s_we_o);
    tick();
    expect_val("t3_adr_hold", 32'h0100_0004); expect_val("t3_grant_hold", 2'b10);
    @(negedge clk); check(s_adr_o); check(grant_o);
    tick(); s_ack_i = 1;
    expect_val("t3_m1_ack", 1);
    @(negedge clk); check(m1_ack_o);
    tick(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    tick();

    // Watchdog abort of m0 after exactly 8 unacked strobe cycles
    n_strobe = 0;
    adr_first = '0;
    expect_val("t4_handover_adr", 32'hDEAD0000);
    expect_val("t4_abort_len", 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!s_cyc_o) break;
      if (i == 0) adr_first = s_adr_o;
      n_strobe++;
    end
    check(adr_first); check(n_strobe);
    expect_val("t4_grant", 0); expect_val("t4_m0_err", 1);
    expect_val("t4_timeout", 1); expect_val("t4_m1_err", 0);
    check(grant_o); check(m0_err_o); check(timeout_o); check(m1_err_o);
    tick(); m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h0100_0010; s_int_i = 1;
    expect_val("t4_err_pulse", 0); expect_val("t4_timeout_pulse", 0); expect_val("t4_abort_grant", 0);
    expect_val("t4_int_abort", 2'b11);
    @(negedge clk); check(m0_err_o); check(timeout_o); check(grant_o); check({m0_int_o, m1_int_o});
    tick(); m0_cyc_i = 0; m0_stb_i = 0;
    expect_val("t4_abort_hold_grant", 0);
    @(negedge clk); check(grant_o);
    tick();
    expect_val("t4_idle_grant", 0); expect_val("t4_int_idle", 2'b11);
    @(negedge clk); check(grant_o); check({m0_int_o, m1_int_o});
    tick();
    expect_val("t4_m1_grant", 2'b10); expect_val("t4_int_grant1", 2'b11);
    @(negedge clk); check(grant_o); check({m0_int_o, m1_int_o});

    // Ack on the 8th strobe cycle wins over the watchdog
    s_int_i = 0;
    repeat (6) tick();
    tick(); s_ack_i = 1; s_dat_i = 32'h5A5A5A5A;
    expect_val("t5_m1_ack", 1); expect_val("t5_m1_dat", 32'h5A5A5A5A);
    @(negedge clk); check(m1_ack_o); check(m1_dat_o);
    tick(); s_ack_i = 0;
    expect_val("t5_grant", 2'b10); expect_val("t5_timeout", 0);
    expect_val("t5_m1_err", 0); expect_val("t5_s_cyc", 1);
    @(negedge clk); check(grant_o); check(timeout_o); check(m1_err_o); check(s_cyc_o);

    // Asynchronous reset mid-grant
    tick(); m0_cyc_i = 1; m0_stb_i = 1;
    #2 rst = 1;
    #1;
    expect_val("t6_async_s_cyc", 0); expect_val("t6_async_grant", 0);
    check(s_cyc_o); check(grant_o);
    tick(); rst = 0;
    tick();
    expect_val("t6_tie_grant", 2'b01);
    @(negedge clk); check(grant_o);
    tick(); m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick();

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
